// File: rtl/prefetch_pkg.sv
// prefetch_pkg: fetch FSM state encoding and the reset fetch pointer (FFFF:0000)
package prefetch_pkg;
  typedef enum logic [1:0] {IDLE, BUS, PUSH_LO, PUSH_HI} state_t;
  localparam logic [15:0] RESET_CS = 16'hFFFF;
  localparam logic [15:0] RESET_IP = 16'h0000;
endpackage

// File: rtl/segment_addr_gen.sv
// segment_addr_gen: real-mode cs:ip to 20-bit physical address, wrapping at 1 MiB
module segment_addr_gen (
  input  logic [15:0] cs,
  input  logic [15:0] ip,
  output logic [19:0] phys
);
  assign phys = {cs, 4'b0} + {4'b0, ip};
endmodule

// File: rtl/instruction_prefetch.sv
// instruction_prefetch: fetches code words at CS:IP and pushes their bytes into the prefetch FIFO; PREFETCH_PERF_COUNTERS_EN adds fetch_count/flush_count
module instruction_prefetch
  import prefetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 6
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            load_new_ip,
  input  logic [15:0]                     new_cs,
  input  logic [15:0]                     new_ip,
  output logic                            mem_access,
  input  logic                            mem_ack,
  output logic [18:0]                     mem_address,
  output logic [1:0]                      mem_bytesel,
  input  logic [15:0]                     mem_data,
  output logic                            fifo_wr_en,
  output logic [7:0]                      fifo_wr_data,
  input  logic                            fifo_full,
  input  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            fifo_reset
`ifdef PREFETCH_PERF_COUNTERS_EN
  ,
  output logic [15:0]                     fetch_count,
  output logic [15:0]                     flush_count
`endif
);
  state_t state, state_n;
  logic [15:0] fetch_cs, fetch_ip, cs_n, ip_n, word, word_n;
  logic [19:0] phys;
  logic [18:0] addr_n;
  logic [1:0] sel_n;
  logic acc_n, abort, abort_n, room;
  segment_addr_gen u_addr (.cs(fetch_cs), .ip(fetch_ip), .phys(phys));
  assign room = 32'(fifo_count) + 32'd2 <= 32'(FIFO_DEPTH);
  // state, pointer, bus request and flush registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      fetch_cs <= RESET_CS;
      fetch_ip <= RESET_IP;
      word <= '0;
      mem_access <= 1'b0;
      mem_address <= '0;
      mem_bytesel <= '0;
      abort <= 1'b0;
      fifo_reset <= 1'b0;
    end else begin
      state <= state_n;
      fetch_cs <= cs_n;
      fetch_ip <= ip_n;
      word <= word_n;
      mem_access <= acc_n;
      mem_address <= addr_n;
      mem_bytesel <= sel_n;
      abort <= abort_n;
      fifo_reset <= load_new_ip;
    end
  // next state: a redirect abandons pending pushes, but a request already on the bus runs to its ack
  always_comb begin
    state_n = state;
    cs_n = load_new_ip ? new_cs : fetch_cs;
    ip_n = load_new_ip ? new_ip : fetch_ip;
    word_n = word;
    acc_n = mem_access;
    addr_n = mem_address;
    sel_n = mem_bytesel;
    abort_n = abort;
    fifo_wr_en = 1'b0;
    fifo_wr_data = 8'h00;
    case (state)
      IDLE: if (!load_new_ip && room) begin
        state_n = BUS;
        acc_n = 1'b1;
        addr_n = phys[19:1];
        sel_n = phys[0] ? 2'b10 : 2'b11;
      end
      BUS: if (mem_ack) begin
        acc_n = 1'b0;
        abort_n = 1'b0;
        word_n = mem_data;
        state_n = (load_new_ip || abort) ? IDLE : fetch_ip[0] ? PUSH_HI : PUSH_LO;
      end else if (load_new_ip) abort_n = 1'b1;
      PUSH_LO, PUSH_HI: begin
        fifo_wr_data = state == PUSH_LO ? word[7:0] : word[15:8];
        fifo_wr_en = !fifo_full && !load_new_ip && !fifo_reset;
        if (load_new_ip) state_n = IDLE;
        else if (fifo_wr_en) begin
          ip_n = fetch_ip + 16'd1;
          state_n = state == PUSH_LO ? PUSH_HI : IDLE;
        end
      end
    endcase
  end
`ifdef PREFETCH_PERF_COUNTERS_EN
  // count acked words that were kept and redirect strobes, both wrapping
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      fetch_count <= fetch_count + 16'(state == BUS && mem_ack && !load_new_ip && !abort);
      flush_count <= flush_count + 16'(load_new_ip);
    end
`endif
endmodule

// File: tb/tb_instruction_prefetch.sv
// tb_instruction_prefetch: vector table, corner sequences and a randomized run against a byte-stream model
`timescale 1ns/1ps
module tb_instruction_prefetch;
  localparam int DEPTH = 6;
  localparam int CW = $clog2(DEPTH+1);
  logic clk = 0, reset_n = 0, load_new_ip = 0, mem_ack = 0, fifo_full = 0;
  logic [15:0] new_cs = '0, new_ip = '0, mem_data = '0;
  logic [CW-1:0] fifo_count = '0;
  logic mem_access, fifo_wr_en, fifo_reset;
  logic [18:0] mem_address;
  logic [1:0] mem_bytesel;
  logic [7:0] fifo_wr_data;
  int passed = 0, total = 0;
`ifdef PREFETCH_PERF_COUNTERS_EN
  logic [15:0] fetch_count, flush_count;
  int kept_m = 0, flush_m = 0;
  bit dirty = 0;
`endif

  always #5 clk = ~clk;

  instruction_prefetch #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .load_new_ip(load_new_ip), .new_cs(new_cs), .new_ip(new_ip),
    .mem_access(mem_access), .mem_ack(mem_ack), .mem_address(mem_address), .mem_bytesel(mem_bytesel),
    .mem_data(mem_data), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
    .fifo_count(fifo_count), .fifo_reset(fifo_reset)
`ifdef PREFETCH_PERF_COUNTERS_EN
    , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
  );

`ifdef PREFETCH_PERF_COUNTERS_EN
  // expected counters: a word is kept unless a redirect arrived between request and ack
  always @(negedge clk)
    if (reset_n) begin
      if (load_new_ip) flush_m <= flush_m + 1;
      if (mem_ack && mem_access) begin
        kept_m <= kept_m + ((dirty || load_new_ip) ? 0 : 1);
        dirty <= 0;
      end else if (load_new_ip && mem_access) dirty <= 1;
    end
`endif

  typedef struct {
    logic ld;
    logic [15:0] cs, ip;
    logic [18:0] addr;
    logic [1:0] sel;
    logic [15:0] data;
    int n;
    logic [7:0] b0, b1;
  } vec_t;
  vec_t vt[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(output bit ok);
    ok = 0;
    for (int i = 0; i < 12 && !ok; i++) begin
      @(negedge clk);
      if (mem_access) ok = 1;
      else tick();
    end
  endtask

  function automatic logic [19:0] phys(input logic [15:0] cs, input logic [15:0] ip);
    int p;
    p = (int'(cs) * 16 + int'(ip)) % (1 << 20);
    return 20'(p);
  endfunction

  function automatic logic [7:0] mbyte(input logic [19:0] p);
    return p[7:0] ^ p[15:8] ^ {p[19:16], p[19:16]} ^ 8'h5A;
  endfunction

  function automatic logic [15:0] mword(input logic [18:0] w);
    return {mbyte({w, 1'b1}), mbyte({w, 1'b0})};
  endfunction

  initial begin
    bit ok, pop, nprev, prev_load, prev_ack, acc_prev, any;
    int n, occ, prev_occ, ack_wait, pushes;
    logic [15:0] mcs, mip;
    logic [18:0] last_addr;
    vt[0]  = '{1'b0, 16'h0000, 16'h0000, 19'h7FFF8, 2'b11, 16'hBEEA, 2, 8'hEA, 8'hBE};
    vt[1]  = '{1'b0, 16'h0000, 16'h0000, 19'h7FFF9, 2'b11, 16'h1122, 2, 8'h22, 8'h11};
    vt[2]  = '{1'b1, 16'h1000, 16'h0003, 19'h08001, 2'b10, 16'h7755, 1, 8'h77, 8'h00};
    vt[3]  = '{1'b0, 16'h0000, 16'h0000, 19'h08002, 2'b11, 16'h3344, 2, 8'h44, 8'h33};
    vt[4]  = '{1'b1, 16'h0000, 16'hFFFE, 19'h07FFF, 2'b11, 16'hCAFE, 2, 8'hFE, 8'hCA};
    vt[5]  = '{1'b0, 16'h0000, 16'h0000, 19'h00000, 2'b11, 16'h0F0E, 2, 8'h0E, 8'h0F};
    vt[6]  = '{1'b1, 16'hF000, 16'hFFF1, 19'h7FFF8, 2'b10, 16'h9988, 1, 8'h99, 8'h00};
    vt[7]  = '{1'b1, 16'hFFFF, 16'h0010, 19'h00000, 2'b11, 16'h5A6B, 2, 8'h6B, 8'h5A};
    vt[8]  = '{1'b1, 16'h1234, 16'h5679, 19'h0BCDC, 2'b10, 16'hD00D, 1, 8'hD0, 8'h00};
    vt[9]  = '{1'b1, 16'hABCD, 16'h0002, 19'h55E69, 2'b11, 16'h4321, 2, 8'h21, 8'h43};
    vt[10] = '{1'b0, 16'h0000, 16'h0000, 19'h55E6A, 2'b11, 16'h8765, 2, 8'h65, 8'h87};
    repeat (3) tick();
    @(negedge clk);
    chk("rst_access", mem_access, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_fifo_reset", fifo_reset, 0);
    chk("rst_address", mem_address, 0);
    chk("rst_bytesel", mem_bytesel, 0);
    chk("rst_wr_data", fifo_wr_data, 0);
    tick();
    reset_n = 1;
    foreach (vt[k]) begin
      fifo_count = 0;
      if (vt[k].ld) begin
        new_cs = vt[k].cs;
        new_ip = vt[k].ip;
        load_new_ip = 1;
        tick();
        load_new_ip = 0;
        @(negedge clk);
        chk("vec_fifo_reset", fifo_reset, 1);
        tick();
      end
      wait_acc(ok);
      chk("vec_fetch_start", ok, 1);
      chk("vec_address", mem_address, vt[k].addr);
      chk("vec_bytesel", mem_bytesel, vt[k].sel);
      tick();
      mem_ack = 1;
      mem_data = vt[k].data;
      fifo_count = CW'(DEPTH);
      tick();
      mem_ack = 0;
      n = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (i == 0) chk("vec_access_drop", mem_access, 0);
        if (fifo_wr_en) begin
          if (n == 0) chk("vec_byte0", fifo_wr_data, vt[k].b0);
          else chk("vec_byte1", fifo_wr_data, vt[k].b1);
          n++;
        end
        tick();
      end
      chk("vec_push_count", n, vt[k].n);
    end
    new_cs = 16'h0000;
    new_ip = 16'h0100;
    load_new_ip = 1;
    fifo_count = CW'(DEPTH - 1);
    tick();
    load_new_ip = 0;
    any = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      any |= mem_access;
      tick();
    end
    chk("thr_no_fetch", any, 0);
    fifo_count = CW'(DEPTH - 2);
    @(negedge clk);
    chk("thr_not_same_cycle", mem_access, 0);
    tick();
    @(negedge clk);
    chk("thr_fetch_start", mem_access, 1);
    chk("thr_address", mem_address, 19'h00080);
    tick();
    new_cs = 16'h2000;
    new_ip = 16'h0010;
    load_new_ip = 1;
    tick();
    load_new_ip = 0;
    any = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) chk("abort_fifo_reset", fifo_reset, 1);
      any &= mem_access;
      tick();
    end
    chk("abort_access_held", any, 1);
    mem_ack = 1;
    mem_data = 16'hDEAD;
    tick();
    mem_ack = 0;
    @(negedge clk);
    chk("abort_access_drop", mem_access, 0);
    chk("abort_no_push0", fifo_wr_en, 0);
    tick();
    @(negedge clk);
    chk("abort_refetch", mem_access, 1);
    chk("abort_no_push1", fifo_wr_en, 0);
    chk("abort_new_address", mem_address, 19'h10008);
    chk("abort_new_bytesel", mem_bytesel, 2'b11);
    tick();
    mem_ack = 1;
    mem_data = 16'h1234;
    fifo_count = CW'(DEPTH);
    tick();
    mem_ack = 0;
    @(negedge clk);
    chk("full_lo_push", fifo_wr_en, 1);
    chk("full_lo_byte", fifo_wr_data, 8'h34);
    tick();
    fifo_full = 1;
    any = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      any |= fifo_wr_en;
      tick();
    end
    chk("full_hold", any, 0);
    fifo_full = 0;
    @(negedge clk);
    chk("full_release_push", fifo_wr_en, 1);
    chk("full_release_byte", fifo_wr_data, 8'h12);
    tick();
    @(negedge clk);
    chk("full_single_push", fifo_wr_en, 0);
    tick();
    fifo_count = 0;
    wait_acc(ok);
    chk("full_next_fetch", ok, 1);
    chk("full_next_address", mem_address, 19'h10009);
    tick();
    mcs = 16'h2000;
    mip = 16'h0012;
    occ = 0;
    prev_occ = 0;
    pushes = 0;
    acc_prev = mem_access;
    nprev = mem_access;
    last_addr = mem_address;
    prev_load = 0;
    prev_ack = 0;
    ack_wait = $urandom_range(0, 3);
    for (int c = 0; c < 3000; c++) begin
      load_new_ip = $urandom_range(0, 39) == 0;
      if (load_new_ip) begin
        new_cs = 16'($urandom);
        new_ip = $urandom_range(0, 3) == 0 ? 16'($urandom_range(16'hFFF8, 16'hFFFF)) : 16'($urandom);
      end
      if (mem_access && !acc_prev) ack_wait = $urandom_range(0, 3);
      mem_ack = mem_access && ack_wait == 0;
      if (mem_access && ack_wait != 0) ack_wait--;
      acc_prev = mem_access;
      mem_data = mword(mem_address);
      fifo_count = CW'(occ);
      fifo_full = occ == DEPTH;
      pop = occ > 0 && $urandom_range(0, 2) == 0;
      @(negedge clk);
      chk("rnd_fifo_reset", fifo_reset, prev_load);
      if (load_new_ip) chk("rnd_no_push_on_load", fifo_wr_en, 0);
      if (fifo_wr_en) begin
        chk("rnd_push_byte", fifo_wr_data, mbyte(phys(mcs, mip)));
        chk("rnd_push_not_full", fifo_full, 0);
        pushes++;
      end
      if (mem_access && !nprev) begin
        chk("rnd_fetch_address", mem_address, phys(mcs, mip) >> 1);
        chk("rnd_fetch_bytesel", mem_bytesel, mip[0] ? 2'b10 : 2'b11);
        chk("rnd_fetch_room", prev_occ <= DEPTH - 2 && !prev_load, 1);
      end
      if (mem_access && nprev) chk("rnd_address_stable", mem_address, last_addr);
      if (prev_ack) chk("rnd_access_drop", mem_access, 0);
      nprev = mem_access;
      last_addr = mem_address;
      prev_load = load_new_ip;
      prev_occ = occ;
      prev_ack = mem_ack;
      if (fifo_wr_en) mip++;
      if (load_new_ip) begin
        mcs = new_cs;
        mip = new_ip;
      end
      occ = fifo_reset ? 0 : occ + (fifo_wr_en ? 1 : 0) - (pop ? 1 : 0);
      tick();
    end
    load_new_ip = 0;
    mem_ack = 0;
    chk("rnd_liveness", pushes >= 300, 1);
`ifdef PREFETCH_PERF_COUNTERS_EN
    chk("fetch_count", fetch_count, 16'(kept_m));
    chk("flush_count", flush_count, 16'(flush_m));
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
